adc_frame_reader: RTL and testbench

ADC_FRAME_READER -- requirements
Module: adc_frame_reader

---
 rtl/adc_frame_reader_pkg.sv | 30 +++
 rtl/adc_frame_reader_frame_byte_mux.sv | 58 +++++
 rtl/adc_frame_reader.sv | 208 ++++++++++++++++++++
 tb/tb_adc_frame_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_frame_reader_pkg.sv
// Shared definitions for the ADC frame reader.
// Holds the FSM state encoding, the default sync byte, the frame-length
// constants and the byte-fold helper used by the checksum.
package adc_frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_TX    = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE         = 8'hA5;
    localparam int         DEFAULT_SAMPLES_PER_FRAME = 4;

    // Sync byte, sequence byte and checksum byte wrap the payload.
    localparam int FRAME_OVERHEAD = 3;

    // Frame length in bytes for a given number of 16-bit samples.
    function automatic int frame_len(input int spf);
        return FRAME_OVERHEAD + 2 * spf;
    endfunction

    localparam int DEFAULT_FRAME_LEN = FRAME_OVERHEAD + 2 * DEFAULT_SAMPLES_PER_FRAME;

    // XOR of the two bytes of a sample; its contribution to the checksum.
    function automatic logic [7:0] sample_fold(input logic [15:0] sample);
        return sample[15:8] ^ sample[7:0];
    endfunction

endpackage

// File: rtl/adc_frame_reader_frame_byte_mux.sv
// Frame byte selector.
// Picks the byte for a given position within a frame:
//   index 0            -> sync byte
//   index 1            -> sequence number
//   index 2+2k / 3+2k  -> MSB / LSB of sample slot k
//   last index         -> checksum (seq XOR all payload bytes)
// Ports:
//   i_byte_idx  byte position within the frame
//   i_seq       current frame sequence number
//   i_samples   sample slots, slot k at bits [16k +: 16]
//   o_byte      selected frame byte
module frame_byte_mux
    import adc_frame_reader_pkg::*;
#(
    parameter int         SAMPLES_PER_FRAME = DEFAULT_SAMPLES_PER_FRAME,
    parameter logic [7:0] SYNC_BYTE         = DEFAULT_SYNC_BYTE,
    parameter int         FRAME_LEN         = frame_len(SAMPLES_PER_FRAME),
    parameter int         IDX_W             = $clog2(FRAME_LEN)
) (
    input  logic [IDX_W-1:0]                i_byte_idx,
    input  logic [7:0]                      i_seq,
    input  logic [16*SAMPLES_PER_FRAME-1:0] i_samples,
    output logic [7:0]                      o_byte
);

    logic [7:0] w_checksum;

    // Running XOR over the sequence byte and every payload byte.
    always_comb begin
        w_checksum = i_seq;
        for (int k = 0; k < SAMPLES_PER_FRAME; k++) begin
            w_checksum = w_checksum ^ sample_fold(i_samples[16*k +: 16]);
        end
    end

    // Byte selection by frame position.
    always_comb begin
        o_byte = 8'h00;
        if (i_byte_idx == IDX_W'(0)) begin
            o_byte = SYNC_BYTE;
        end else if (i_byte_idx == IDX_W'(1)) begin
            o_byte = i_seq;
        end else if (i_byte_idx == IDX_W'(FRAME_LEN - 1)) begin
            o_byte = w_checksum;
        end else begin
            for (int k = 0; k < SAMPLES_PER_FRAME; k++) begin
                if (i_byte_idx == IDX_W'(2 + 2 * k)) begin
                    o_byte = i_samples[16*k+8 +: 8];
                end else if (i_byte_idx == IDX_W'(3 + 2 * k)) begin
                    o_byte = i_samples[16*k +: 8];
                end else begin
                    o_byte = o_byte;
                end
            end
        end
    end

endmodule

// File: rtl/adc_frame_reader.sv
// ADC frame reader.
// Pulls SAMPLES_PER_FRAME samples from a sample FIFO, then streams them out
// as a byte frame: sync, seq, MSB/LSB per sample, checksum. Reads and
// transmission never overlap; the output handshake is valid/ready.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   one-sample read strobe (data returns the following cycle)
//   fifo_data    FIFO read data
//   tx_data      frame byte, held while tx_ready is low
//   tx_valid     tx_data is valid (high throughout transmission)
//   tx_ready     downstream accepts the byte this cycle
//   busy         FSM is not idle
//   frame_count  number of completed frames, wrapping at 16 bits
module adc_frame_reader
    import adc_frame_reader_pkg::*;
#(
    parameter int         DATA_WIDTH        = 16,
    parameter int         SAMPLES_PER_FRAME = DEFAULT_SAMPLES_PER_FRAME,
    parameter logic [7:0] SYNC_BYTE         = DEFAULT_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    localparam int FRAME_LEN = frame_len(SAMPLES_PER_FRAME);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int CNT_W     = $clog2(SAMPLES_PER_FRAME + 1);

    state_t                          r_state;
    state_t                          w_next_state;
    logic                            r_busy;
    logic                            r_tx_valid;
    logic [7:0]                      r_tx_data;
    logic [7:0]                      r_seq;
    logic [15:0]                     r_frame_count;
    logic [IDX_W-1:0]                r_byte_idx;
    logic [CNT_W-1:0]                r_rd_cnt;
    logic [CNT_W-1:0]                r_cap_cnt;
    logic                            r_rd_pend;
    logic [15:0]                     r_slots [SAMPLES_PER_FRAME];

    logic                            w_rd_en;
    logic                            w_accept;
    logic                            w_last_byte;
    logic                            w_last_capture;
    logic                            w_start_tx;
    logic                            w_frame_done;
    logic [IDX_W-1:0]                w_mux_idx;
    logic [7:0]                      w_mux_byte;
    logic [16*SAMPLES_PER_FRAME-1:0] w_samples;

    // The read strobe must react to fifo_empty in the same cycle, so it is
    // decoded from registered state rather than registered itself.
    assign fifo_rd_en  = w_rd_en;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;

    // Control decode: read strobe, handshake, frame boundaries, next state.
    always_comb begin
        w_rd_en        = 1'b0;
        w_accept       = 1'b0;
        w_last_byte    = 1'b0;
        w_last_capture = 1'b0;
        w_start_tx     = 1'b0;
        w_frame_done   = 1'b0;
        w_mux_idx      = {IDX_W{1'b0}};
        w_next_state   = r_state;

        w_rd_en        = (r_state == ST_FETCH) && !fifo_empty
                         && (r_rd_cnt < CNT_W'(SAMPLES_PER_FRAME));
        w_accept       = (r_state == ST_TX) && r_tx_valid && tx_ready;
        w_last_byte    = (r_byte_idx == IDX_W'(FRAME_LEN - 1));
        // The final sample lands in its slot at the end of this cycle.
        w_last_capture = r_rd_pend && (r_cap_cnt == CNT_W'(SAMPLES_PER_FRAME - 1));
        w_start_tx     = (r_state == ST_FETCH) && w_last_capture;
        w_frame_done   = w_accept && w_last_byte;

        // Look one byte ahead so the next byte is registered on acceptance.
        if (r_state == ST_TX) begin
            w_mux_idx = r_byte_idx + IDX_W'(1);
        end else begin
            w_mux_idx = {IDX_W{1'b0}};
        end

        case (r_state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (w_last_capture) begin
                    w_next_state = ST_TX;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_TX: begin
                if (w_frame_done) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_TX;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Flatten sample slots for the byte selector.
    always_comb begin
        w_samples = {(16*SAMPLES_PER_FRAME){1'b0}};
        for (int k = 0; k < SAMPLES_PER_FRAME; k++) begin
            w_samples[16*k +: 16] = r_slots[k];
        end
    end

    frame_byte_mux #(
        .SAMPLES_PER_FRAME (SAMPLES_PER_FRAME),
        .SYNC_BYTE         (SYNC_BYTE),
        .FRAME_LEN         (FRAME_LEN),
        .IDX_W             (IDX_W)
    ) u_frame_byte_mux (
        .i_byte_idx (w_mux_idx),
        .i_seq      (r_seq),
        .i_samples  (w_samples),
        .o_byte     (w_mux_byte)
    );

    // FSM state register with registered busy / tx_valid derived from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_tx_valid <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_busy     <= (w_next_state != ST_IDLE);
            r_tx_valid <= (w_next_state == ST_TX);
        end
    end

    // Sample fetch: issued-read count, pending read and slot capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt  <= {CNT_W{1'b0}};
            r_cap_cnt <= {CNT_W{1'b0}};
            r_rd_pend <= 1'b0;
            for (int k = 0; k < SAMPLES_PER_FRAME; k++) begin
                r_slots[k] <= 16'h0000;
            end
        end else begin
            r_rd_pend <= w_rd_en;
            if (w_frame_done) begin
                r_rd_cnt  <= {CNT_W{1'b0}};
                r_cap_cnt <= {CNT_W{1'b0}};
            end else begin
                if (w_rd_en) begin
                    r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                end
                if (r_rd_pend) begin
                    for (int k = 0; k < SAMPLES_PER_FRAME; k++) begin
                        if (r_cap_cnt == CNT_W'(k)) begin
                            r_slots[k] <= 16'(fifo_data);
                        end
                    end
                    r_cap_cnt <= r_cap_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Frame transmit: byte index, output byte, sequence and frame counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_idx    <= {IDX_W{1'b0}};
            r_tx_data     <= 8'h00;
            r_seq         <= 8'h00;
            r_frame_count <= 16'h0000;
        end else if (w_start_tx) begin
            r_byte_idx <= {IDX_W{1'b0}};
            r_tx_data  <= w_mux_byte;
        end else if (w_frame_done) begin
            r_byte_idx    <= {IDX_W{1'b0}};
            r_tx_data     <= 8'h00;
            r_seq         <= r_seq + 8'h01;
            r_frame_count <= r_frame_count + 16'h0001;
        end else if (w_accept) begin
            r_byte_idx <= w_mux_idx;
            r_tx_data  <= w_mux_byte;
        end
    end

endmodule

// File: tb/tb_adc_frame_reader.sv
module tb_adc_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Default-width instance
    logic        fifo_empty, fifo_rd_en, tx_valid, tx_ready, busy;
    logic [15:0] fifo_data, frame_count;
    logic [7:0]  tx_data;

    // 12-bit instance
    logic        fifo_empty2, fifo_rd_en2, tx_valid2, tx_ready2, busy2;
    logic [11:0] fifo_data2;
    logic [15:0] frame_count2;
    logic [7:0]  tx_data2;

    adc_frame_reader dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_data(fifo_data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .frame_count(frame_count)
    );

    adc_frame_reader #(.DATA_WIDTH(12)) dut12 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2),
        .fifo_data(fifo_data2), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .busy(busy2), .frame_count(frame_count2)
    );

    // FIFO models: pushes come from the stimulus, pops from the read strobe
    logic [15:0] fmem [0:2047];
    int          pushed = 0;
    int          popped = 0;
    logic        hold_empty;
    assign fifo_empty = hold_empty || (pushed == popped);
    always @(posedge clk) begin
        if (fifo_rd_en && (pushed != popped)) begin
            fifo_data <= fmem[popped];
            popped    <= popped + 1;
        end
    end

    logic [11:0] fmem2 [0:15];
    int          pushed2 = 0;
    int          popped2 = 0;
    assign fifo_empty2 = (pushed2 == popped2);
    always @(posedge clk) begin
        if (fifo_rd_en2 && (pushed2 != popped2)) begin
            fifo_data2 <= fmem2[popped2];
            popped2    <= popped2 + 1;
        end
    end

    // Byte sinks
    logic [7:0] rx  [0:4095];
    int         rx_n = 0;
    logic [7:0] rx2 [0:63];
    int         rx2_n = 0;
    int         bad_rd = 0;
    always @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            rx[rx_n] <= tx_data;
            rx_n     <= rx_n + 1;
        end
        if (tx_valid2 && tx_ready2) begin
            rx2[rx2_n] <= tx_data2;
            rx2_n      <= rx2_n + 1;
        end
    end
    always @(negedge clk) begin
        if ((fifo_rd_en && fifo_empty) || (fifo_rd_en2 && fifo_empty2)) begin
            bad_rd <= bad_rd + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push4(input logic [63:0] smp);
        for (int i = 0; i < 4; i++) begin
            fmem[pushed] = smp[63-16*i -: 16];
            pushed = pushed + 1;
        end
    endtask

    task automatic wait_fc(input logic [15:0] fc, input string name);
        int n = 0;
        while (frame_count !== fc && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(frame_count), 32'(fc));
    endtask

    task automatic wait_byte(input int base, input int k, input string name);
        int n = 0;
        while (!(((rx_n - base) == k) && tx_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(rx_n - base), 32'(k));
    endtask

    task automatic check_frame(input int base, input logic [87:0] exp, input string name);
        check($sformatf("%s_len", name), 32'(rx_n - base), 32'd11);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("%s_b%0d", name, i), 32'(rx[base+i]), 32'(exp[87-8*i -: 8]));
        end
    endtask

    typedef struct packed {
        logic [63:0] smp;   // sample 0 in the top 16 bits
        logic [87:0] exp;   // byte 0 in the top 8 bits
        logic [15:0] fc;    // frame_count after the frame
    } vec_t;

    vec_t vecs [3];

    initial begin
        int base;
        int p0;
        logic [7:0] exp_seq;

        vecs[0] = '{smp: 64'h0123_0456_0789_0ABC,
                    exp: 88'hA5_00_01_23_04_56_07_89_0A_BC_48, fc: 16'd1};
        vecs[1] = '{smp: 64'hFFFF_0000_8001_1234,
                    exp: 88'hA5_01_FF_FF_00_00_80_01_12_34_A6, fc: 16'd2};
        vecs[2] = '{smp: 64'h5A5A_A5A5_0F0F_F0F0,
                    exp: 88'hA5_02_5A_5A_A5_A5_0F_0F_F0_F0_02, fc: 16'd3};

        reset = 1'b1;
        tx_ready = 1'b1;
        tx_ready2 = 1'b1;
        hold_empty = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        reset = 1'b0;

        // Reset pulsed while byte 6 is presented
        base = rx_n;
        push4(64'h7777_8888_9999_AAAA);
        wait_byte(base, 6, "abort_reach_b6");
        check("abort_b6_data", 32'(tx_data), 32'h99);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_frame_count", 32'(frame_count), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_resend", 32'(tx_valid), 32'd0);

        // Table-driven frames
        for (int v = 0; v < 3; v++) begin
            base = rx_n;
            push4(vecs[v].smp);
            wait_fc(vecs[v].fc, $sformatf("vec%0d_fc", v));
            check_frame(base, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Backpressure: tx_ready low for 5 cycles while byte 3 is presented
        base = rx_n;
        push4(64'h1234_5678_9ABC_DEF0);
        wait_byte(base, 3, "stall_reach_b3");
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_valid_%0d", i), 32'(tx_valid), 32'd1);
            check($sformatf("stall_data_%0d", i), 32'(tx_data), 32'h34);
            @(negedge clk);
        end
        check("stall_no_consume", 32'(rx_n - base), 32'd3);
        tx_ready = 1'b1;
        wait_fc(16'd4, "stall_fc");
        check_frame(base, 88'hA5_03_12_34_56_78_9A_BC_DE_F0_03, "stall");

        // FIFO runs dry after two reads for 10 cycles
        base = rx_n;
        p0 = popped;
        fmem[pushed] = 16'h0AAA; pushed = pushed + 1;
        fmem[pushed] = 16'h0BBB; pushed = pushed + 1;
        for (int n = 0; n < 100 && (popped - p0) < 2; n++) @(negedge clk);
        check("dry_two_reads", 32'(popped - p0), 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("dry_rd_en_%0d", i), 32'(fifo_rd_en), 32'd0);
            check($sformatf("dry_busy_%0d", i), 32'(busy && !tx_valid), 32'd1);
        end
        fmem[pushed] = 16'h0CCC; pushed = pushed + 1;
        fmem[pushed] = 16'h0DDD; pushed = pushed + 1;
        wait_fc(16'd5, "dry_fc");
        check("dry_four_reads", 32'(popped - p0), 32'd4);
        check_frame(base, 88'hA5_04_0A_AA_0B_BB_0C_CC_0D_DD_04, "dry");

        // Consecutive frames up to frame 257; zero payload makes checksum = seq
        for (int f = 6; f <= 257; f++) begin
            base = rx_n;
            push4(64'h0);
            wait_fc(16'(f), $sformatf("run_fc_%0d", f));
            exp_seq = 8'((f - 1) % 256);
            check($sformatf("run_seq_%0d", f), 32'(rx[base+1]), 32'(exp_seq));
            check($sformatf("run_cks_%0d", f), 32'(rx[base+10]), 32'(exp_seq));
        end
        check("f257_seq", 32'(rx[rx_n-10]), 32'h00);
        check("f257_frame_count", 32'(frame_count), 32'd257);

        // 12-bit samples are zero-extended to 16 bits
        fmem2[0] = 12'hFFF; fmem2[1] = 12'h800; fmem2[2] = 12'h001; fmem2[3] = 12'h0AB;
        pushed2 = 4;
        for (int n = 0; n < 400 && frame_count2 != 16'd1; n++) @(negedge clk);
        check("w12_fc", 32'(frame_count2), 32'd1);
        check("w12_len", 32'(rx2_n), 32'd11);
        begin
            logic [87:0] e12;
            e12 = 88'hA5_00_0F_FF_08_00_00_01_00_AB_52;
            for (int i = 0; i < 11; i++) begin
                check($sformatf("w12_b%0d", i), 32'(rx2[i]), 32'(e12[87-8*i -: 8]));
            end
        end

        check("rd_en_while_empty", 32'(bad_rd), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
